if_id_buffer: RTL and testbench
===============================

# if_id_buffer

Two-entry (parameterisable) instruction queue between the fetch stage and the decode stage. It captures the fetched PC, PC+4 and instruction word, and presents them in order to decode with a valid flag. It applies backpressure to fetch through a stall output and discards all queued instructions when a taken branch resolves in EX.

## Interface
- DEPTH, 2: number of queue entries; a power of two, ≥ 2.
- NOP_INST, 32'h0000_0013: instruction word presented to decode when the queue is empty.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset, sampled at rising clk).
- if_PC_in  in  32  PC of the fetched instruction.
- if_NPC_in  in  32  PC+4 of the fetched instruction.
- if_IR_in  in  32  fetched instruction word.
- if_valid_inst_in  in  1  fetched instruction is real; push request.
- ex_take_branch_out  in  1  taken branch resolved in EX; flush request.
- id_ready  in  1  decode consumes the head entry this cycle; pop request.
- if_stall_out  out  1  queue full; drives the fetch stall enable.
- if_id_PC  out  32  head-entry PC.
- if_id_NPC  out  32  head-entry PC+4.
- if_id_IR  out  32  head-entry instruction.
- if_id_valid_inst  out  1  head entry is valid.
- if_id_count  out  $clog2(DEPTH)+1  number of occupied entries.

## Operation
- Storage: DEPTH entries of {PC, NPC, IR}. Read pointer and write pointer are each $clog2(DEPTH) bits and wrap modulo DEPTH. A count register holds 0..DEPTH.
- full = (count == DEPTH). empty = (count == 0).
- Push: if_valid_inst_in & ~full & ex_take_branch_out == 0. Writes the entry at the write pointer, then increments the write pointer.
- Pop: id_ready & ~empty & ex_take_branch_out == 0. Increments the read pointer.
- Count update: +1 on push only, −1 on pop only, unchanged on push and pop together.
- A full queue does not accept a push, even if a pop happens in the same cycle. if_stall_out is registered-state based, so fetch sees no combinational path from id_ready.
- Flush: ex_take_branch_out = 1 forces count, read pointer and write pointer to 0. Any push or pop in that cycle is ignored. Flush has priority over push and pop.
- Outputs when not empty: if_id_PC, if_id_NPC and if_id_IR show the entry at the read pointer, and if_id_valid_inst = 1.
- Outputs when empty: if_id_PC = 0, if_id_NPC = 0, if_id_IR = NOP_INST, if_id_valid_inst = 0.
- if_stall_out = full. if_id_count = count.
- Reset has priority over everything.
  - Count and both pointers go to 0.
  - Storage contents are not reset; the empty-output gating hides them.

## Timing
- Reset values, from the first edge with rst = 0:
  - if_stall_out = 0, if_id_valid_inst = 0, if_id_IR = NOP_INST
  - if_id_PC = 0, if_id_NPC = 0, if_id_count = 0
- Latency: an instruction pushed at edge N appears on the if_id_* outputs from just after edge N. There is no same-cycle bypass; a push into an empty queue is never visible before its clock edge.
- Pop at edge N: the next entry, or the empty state, is shown from just after edge N.
- if_stall_out rises in the cycle after the push that fills the queue. It falls in the cycle after the first pop from full.
- Flush at edge N: from just after edge N, the queue is empty and if_stall_out = 0. An instruction fetched in the flush cycle is lost, because fetch redirects.
- Reset asserted mid-operation: the same empty state appears after the reset edge, regardless of any push, pop or flush in that cycle.
- Pointer wrap: after write pointer DEPTH−1, the next push goes to entry 0. Order is preserved across the wrap.

## Test plan
- Reset: hold rst = 0 for 2 cycles while driving if_valid_inst_in = 1 → after release, count = 0, valid = 0, IR = 32'h0000_0013, stall = 0.
- Fill: id_ready = 0; push PC 0x0 and then PC 0x4 → count = 2, stall = 1, head PC = 0x0. A third push (PC 0x8) is dropped; count stays 2.
- Drain in order: from full, id_ready = 1 with no push → head PC 0x0, then 0x4, then empty (valid = 0, PC = 0). Stall falls after the first pop.
- Simultaneous: count = 1 (PC 0x10); push 0x14 and pop in the same cycle → count stays 1, head PC = 0x14.
- Flush: full queue; flush, push and pop all asserted together → count = 0, valid = 0, stall = 0. The pushed instruction never appears.
- Wrap and mid-op reset:
  - Stream PCs 0x0–0x20 with id_ready toggling every cycle → decode sees all 9 PCs in order, with no loss or duplication.
  - Assert rst = 0 with count = 2 → empty next cycle.

Source files
------------

// File: rtl/if_id_buffer.sv
// Small in-order instruction queue between fetch and decode.
// Buffers {PC, NPC, IR}, stalls fetch when full and drops everything on a taken branch.
module if_id_buffer #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                if_PC_in,
  input  logic [31:0]                if_NPC_in,
  input  logic [31:0]                if_IR_in,
  input  logic                       if_valid_inst_in,
  input  logic                       ex_take_branch_out,
  input  logic                       id_ready,
  output logic                       if_stall_out,
  output logic [31:0]                if_id_PC,
  output logic [31:0]                if_id_NPC,
  output logic [31:0]                if_id_IR,
  output logic                       if_id_valid_inst,
  output logic [$clog2(DEPTH):0]     if_id_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] ir;
  } entry_t;

  entry_t             entry_mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [CNT_W-1:0]   count_next;

  logic full;
  logic empty;
  logic push;
  logic pop;
  entry_t head;

  assign full  = (count_reg == CNT_W'(DEPTH));
  assign empty = (count_reg == '0);

  // Full blocks a push even when a pop frees a slot this cycle, keeping stall registered.
  assign push = if_valid_inst_in & ~full  & ~ex_take_branch_out;
  assign pop  = id_ready         & ~empty & ~ex_take_branch_out;

  always_comb begin
    count_next = count_reg;
    unique case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst || ex_take_branch_out) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_next;
    end
  end

  // Storage is never cleared; the empty gating below hides stale contents.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      entry_mem[wr_ptr_reg] <= '{pc: if_PC_in, npc: if_NPC_in, ir: if_IR_in};
    end
  end

  assign head = entry_mem[rd_ptr_reg];

  assign if_stall_out     = full;
  assign if_id_count      = count_reg;
  assign if_id_valid_inst = ~empty;
  assign if_id_PC         = empty ? 32'h0 : head.pc;
  assign if_id_NPC        = empty ? 32'h0 : head.npc;
  assign if_id_IR         = empty ? NOP_INST : head.ir;

endmodule

// File: tb/tb_if_id_buffer.sv
// Randomized and directed bench for if_id_buffer against a queue-based reference model.
module tb_if_id_buffer;

  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_PC_in, if_NPC_in, if_IR_in;
  logic        if_valid_inst_in, ex_take_branch_out, id_ready;
  logic        if_stall_out;
  logic [31:0] if_id_PC, if_id_NPC, if_id_IR;
  logic        if_id_valid_inst;
  logic [$clog2(DEPTH):0] if_id_count;

  if_id_buffer #(.DEPTH(DEPTH), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst),
    .if_PC_in(if_PC_in), .if_NPC_in(if_NPC_in), .if_IR_in(if_IR_in),
    .if_valid_inst_in(if_valid_inst_in), .ex_take_branch_out(ex_take_branch_out),
    .id_ready(id_ready), .if_stall_out(if_stall_out),
    .if_id_PC(if_id_PC), .if_id_NPC(if_id_NPC), .if_id_IR(if_id_IR),
    .if_id_valid_inst(if_id_valid_inst), .if_id_count(if_id_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] ir;
  } ent_t;

  ent_t        model_q[$];
  logic [31:0] seen_pc[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    int sz;
    sz = model_q.size();
    check({tag, ".count"}, 32'(if_id_count), 32'(sz));
    check({tag, ".stall"}, 32'(if_stall_out), (sz == DEPTH) ? 32'd1 : 32'd0);
    check({tag, ".valid"}, 32'(if_id_valid_inst), (sz != 0) ? 32'd1 : 32'd0);
    check({tag, ".pc"},  if_id_PC,  (sz != 0) ? model_q[0].pc  : 32'h0);
    check({tag, ".npc"}, if_id_NPC, (sz != 0) ? model_q[0].npc : 32'h0);
    check({tag, ".ir"},  if_id_IR,  (sz != 0) ? model_q[0].ir  : NOP);
  endtask

  // One clock: drive, clock, update model from pre-edge state, check 1ns after the edge.
  task automatic step(input string tag, input logic r, input logic v, input logic br,
                      input logic rdy, input logic [31:0] pc);
    ent_t e;
    logic do_push, do_pop;
    e.pc  = pc;
    e.npc = pc + 32'd4;
    e.ir  = $urandom;
    rst = r; if_valid_inst_in = v; ex_take_branch_out = br; id_ready = rdy;
    if_PC_in = e.pc; if_NPC_in = e.npc; if_IR_in = e.ir;
    @(posedge clk);
    if (!r || br) begin
      model_q.delete();
    end else begin
      do_push = v && (model_q.size() < DEPTH);
      do_pop  = rdy && (model_q.size() > 0);
      if (do_pop) begin
        seen_pc.push_back(model_q[0].pc);
        void'(model_q.pop_front());
      end
      if (do_push) model_q.push_back(e);
    end
    #1;
    check_outputs(tag);
  endtask

  initial begin
    int cyc;
    logic [31:0] fpc;
    logic fv;
    rst = 1'b0; if_valid_inst_in = 1'b0; ex_take_branch_out = 1'b0; id_ready = 1'b0;
    if_PC_in = '0; if_NPC_in = '0; if_IR_in = '0;

    // Reset held with a push request present
    step("reset0", 1'b0, 1'b1, 1'b0, 1'b0, 32'h100);
    step("reset1", 1'b0, 1'b1, 1'b0, 1'b0, 32'h104);
    check("reset_ir_const", if_id_IR, 32'h0000_0013);

    // Fill, then overflow push dropped
    step("fill0", 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    step("fill1", 1'b1, 1'b1, 1'b0, 1'b0, 32'h4);
    check("fill_stall_const", 32'(if_stall_out), 32'd1);
    step("fill_drop", 1'b1, 1'b1, 1'b0, 1'b0, 32'h8);
    check("fill_drop_count", 32'(if_id_count), 32'd2);
    check("fill_head_pc", if_id_PC, 32'h0);

    // Full + pop + push: push must be refused
    step("full_popush", 1'b1, 1'b1, 1'b0, 1'b1, 32'hC);
    check("full_popush_count", 32'(if_id_count), 32'd1);

    // Drain
    step("drain0", 1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
    check("drain_empty_pc", if_id_PC, 32'h0);

    // Simultaneous push and pop with one entry
    step("simul0", 1'b1, 1'b1, 1'b0, 1'b0, 32'h10);
    step("simul1", 1'b1, 1'b1, 1'b0, 1'b1, 32'h14);
    check("simul_head", if_id_PC, 32'h14);

    // Flush with push and pop together
    step("flpre", 1'b1, 1'b1, 1'b0, 1'b0, 32'h18);
    step("flush", 1'b1, 1'b1, 1'b1, 1'b1, 32'h1C);
    check("flush_valid", 32'(if_id_valid_inst), 32'd0);

    // Mid-op reset with two entries
    step("mr0", 1'b1, 1'b1, 1'b0, 1'b0, 32'h20);
    step("mr1", 1'b1, 1'b1, 1'b0, 1'b0, 32'h24);
    step("midrst", 1'b0, 1'b1, 1'b0, 1'b1, 32'h28);
    check("midrst_count", 32'(if_id_count), 32'd0);

    // Stream 0x0..0x20 with id_ready toggling; fetch holds its PC while stalled
    seen_pc.delete();
    fpc = 32'h0;
    cyc = 0;
    while ((seen_pc.size() < 9) && (cyc < 200)) begin
      fv = (fpc <= 32'h20) && !if_stall_out;
      step("stream", 1'b1, fv, 1'b0, cyc[0], fpc);
      if (fv) fpc = fpc + 32'd4;
      cyc++;
    end
    check("stream_timeout", (cyc < 200) ? 32'd1 : 32'd0, 32'd1);
    check("stream_len", 32'(seen_pc.size()), 32'd9);
    for (int i = 0; i < 9 && i < seen_pc.size(); i++)
      check($sformatf("stream_pc%0d", i), seen_pc[i], 32'(i * 4));

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      step("rand", ($urandom_range(0, 31) != 0), $urandom_range(0, 1) == 1,
           ($urandom_range(0, 15) == 0), $urandom_range(0, 1) == 1, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
